// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// States, datapath mux selects, ALU operations and opcodes.
package mcu_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_UPPER,
      S_ALUWB,
      S_BRANCH,
      S_JALRADR,
      S_JAL,
      S_TRAP
   } state_e;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_ALT = 7'b0100000;

   function automatic logic [2:0] imm_src(input logic [6:0] op);
      unique case (op)
         OP_STORE:         imm_src = IMM_S;
         OP_BRANCH:        imm_src = IMM_B;
         OP_LUI, OP_AUIPC: imm_src = IMM_U;
         OP_JAL:           imm_src = IMM_J;
         default:          imm_src = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select from control state and instruction fields.
// Only EXECR/EXECI/BRANCH pick non-add operations.
module alu_decoder
   import mcu_pkg::*;
(
   input  state_e      state,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   output logic [3:0]  alu_ctl
);

   logic alt;
   logic is_r;

   assign alt  = (funct7 == F7_ALT);
   assign is_r = (state == S_EXECR);

   // funct3 map; sub only exists for register-register ops
   always_comb begin
      alu_ctl = ALU_ADD;
      case (state)
         S_EXECR, S_EXECI: begin
            unique case (funct3)
               3'b000: alu_ctl = (is_r && alt) ? ALU_SUB : ALU_ADD;
               3'b001: alu_ctl = ALU_SLL;
               3'b010: alu_ctl = ALU_SLT;
               3'b011: alu_ctl = ALU_SLTU;
               3'b100: alu_ctl = ALU_XOR;
               3'b101: alu_ctl = alt ? ALU_SRA : ALU_SRL;
               3'b110: alu_ctl = ALU_OR;
               3'b111: alu_ctl = ALU_AND;
            endcase
         end
         S_BRANCH: alu_ctl = ALU_SUB;
         default:  alu_ctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM over a shared memory with ready handshake.
// Moore outputs per state, qualified by mem_ready and branch outcome.
module multicycle_control_unit
   import mcu_pkg::*;
#(
   parameter bit EXT_BRANCH = 1'b1,
   parameter bit TRAP_HALT  = 1'b1,
   parameter int ALU_CTRL_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            op,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic                  Zero,
   input  logic                  Lt,
   input  logic                  Ltu,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  AdrSrc,
   output logic                  IRWrite,
   output logic                  PCWrite,
   output logic                  MemWrite,
   output logic                  RegWrite,
   output logic [1:0]            ResultSrc,
   output logic [1:0]            ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic [2:0]            ImmSrc,
   output logic                  illegal,
   output logic                  retire
);

   state_e     state_q, state_d;
   logic [3:0] alu_ctl;
   logic       br_legal;
   logic       taken;

   alu_decoder u_alu_dec (
      .state   (state_q),
      .funct3  (funct3),
      .funct7  (funct7),
      .alu_ctl (alu_ctl)
   );

   // beq is always legal; the rest need EXT_BRANCH and exclude 010/011
   assign br_legal = (funct3 == 3'b000) ||
                     (EXT_BRANCH && (funct3[2:1] != 2'b01));

   assign ALUControl = rst_n ? ALU_CTRL_W'(alu_ctl) : '0;

   // State register; reset returns straight to FETCH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state sequencing
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_BRANCH:         state_d = br_legal ? S_BRANCH : S_TRAP;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = (funct3 == 3'b000) ? S_JALRADR
                                                               : S_TRAP;
               OP_LUI, OP_AUIPC:  state_d = S_UPPER;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECR, S_EXECI, S_UPPER: state_d = S_ALUWB;
         S_JALRADR:  state_d = S_JAL;
         S_JAL:      state_d = S_ALUWB;
         S_TRAP:     if (!TRAP_HALT) state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // Branch outcome from ALU flags of rs1 - rs2
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = Zero;
         3'b001:  taken = !Zero;
         3'b100:  taken = Lt;
         3'b101:  taken = !Lt;
         3'b110:  taken = Ltu;
         3'b111:  taken = !Ltu;
         default: taken = 1'b0;
      endcase
   end

   // Per-state datapath controls, all gated off while in reset
   always_comb begin
      mem_req   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RD2;
      ImmSrc    = imm_src(op);
      illegal   = 1'b0;
      retire    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
            IRWrite   = mem_ready;
            PCWrite   = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR, S_EXECI, S_JALRADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            retire    = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req  = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = mem_ready;
            retire   = mem_ready;
         end
         S_EXECR: ALUSrcA = SRCA_RD1;
         S_UPPER: begin
            ALUSrcA = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = SRCA_RD1;
            PCWrite = taken;
            retire  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
         end
         S_TRAP:  illegal = 1'b1;
         default: ;
      endcase
      if (!rst_n) begin
         mem_req   = 1'b0;
         AdrSrc    = 1'b0;
         IRWrite   = 1'b0;
         PCWrite   = 1'b0;
         MemWrite  = 1'b0;
         RegWrite  = 1'b0;
         ResultSrc = 2'b00;
         ALUSrcA   = 2'b00;
         ALUSrcB   = 2'b00;
         ImmSrc    = 3'b000;
         illegal   = 1'b0;
         retire    = 1'b0;
      end
   end

endmodule
